// File: rtl/gmii_pkg.sv
// ---------------------------------------------------------------------------
// gmii_pkg
// Shared types for the GMII/MII lane adapter:
//   speed_t    - encoding of the link speed as seen on the speed/active_speed
//                ports
//   tx_state_t - nibble serialiser state for the MII transmit path
//   norm_speed - maps the reserved code 2'b11 onto 1000M
// ---------------------------------------------------------------------------
package gmii_pkg;

   typedef enum logic [1:0] {
      SPEED_10M   = 2'b00,
      SPEED_100M  = 2'b01,
      SPEED_1000M = 2'b10
   } speed_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOW  = 2'b01,
      HIGH = 2'b10
   } tx_state_t;

   // Reserved code 2'b11 is treated as gigabit.
   function automatic speed_t norm_speed(input logic [1:0] raw);
      speed_t s;
      case (raw)
         2'b00:   s = SPEED_10M;
         2'b01:   s = SPEED_100M;
         default: s = SPEED_1000M;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/gmii_ce_gen.sv
// ---------------------------------------------------------------------------
// gmii_ce_gen
// Nibble-rate clock-enable generator.
//   clk, rst_n - clock and asynchronous active-low reset
//   speed      - currently applied speed
//   clear      - restart the divider at 0 on this edge
//   ce         - 1 every cycle at 1000M; at 100M/10M, 1 on the last count
//                of each divider period
// ---------------------------------------------------------------------------
module gmii_ce_gen
   import gmii_pkg::*;
#(
   parameter int CLK_DIV_100M = 5,
   parameter int CLK_DIV_10M  = 50,
   parameter int DIV_WIDTH    = 6
) (
   input  logic   clk,
   input  logic   rst_n,
   input  speed_t speed,
   input  logic   clear,
   output logic   ce
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;
   logic [DIV_WIDTH-1:0] div_last_s;

   // Terminal count for the active MII rate.
   always_comb begin
      div_last_s = DIV_WIDTH'(CLK_DIV_10M - 1);
      if (speed == SPEED_100M) begin
         div_last_s = DIV_WIDTH'(CLK_DIV_100M - 1);
      end else begin
         div_last_s = DIV_WIDTH'(CLK_DIV_10M - 1);
      end
   end

   assign ce = (speed == SPEED_1000M) || (cnt_q == div_last_s);

   // Divider next value: held at 0 in gigabit mode and on a speed change.
   always_comb begin
      cnt_d = cnt_q;
      if (clear || ce) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
   end

   // Divider register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gmii_mii_lane_adapter.sv
// ---------------------------------------------------------------------------
// gmii_mii_lane_adapter
// Byte-wide MAC to GMII/MII PHY adapter in a single 125 MHz clock domain.
//   speed / active_speed           - requested / applied speed
//   mac_txd, mac_tx_en, mac_tx_er  - TX byte stream from MAC
//   mac_tx_ready                   - byte accepted this cycle
//   phy_txd, phy_tx_en, phy_tx_er  - TX to PHY (byte at 1000M, low-first
//                                    nibble in [3:0] at 100M/10M)
//   phy_tx_ce                      - PHY TX outputs updated this cycle
//   phy_rxd, phy_rx_dv, phy_rx_er  - RX from PHY, qualified by phy_rx_ce
//   mac_rxd, mac_rx_dv, mac_rx_er  - RX byte to MAC, qualified by
//                                    mac_rx_valid
//   rx_odd_nibble                  - pulse: RX frame ended on a half byte
// ---------------------------------------------------------------------------
module gmii_mii_lane_adapter
   import gmii_pkg::*;
#(
   parameter int CLK_DIV_100M = 5,
   parameter int CLK_DIV_10M  = 50,
   parameter int DIV_WIDTH    = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] speed,
   output logic [1:0] active_speed,
   input  logic [7:0] mac_txd,
   input  logic       mac_tx_en,
   input  logic       mac_tx_er,
   output logic       mac_tx_ready,
   output logic [7:0] phy_txd,
   output logic       phy_tx_en,
   output logic       phy_tx_er,
   output logic       phy_tx_ce,
   input  logic [7:0] phy_rxd,
   input  logic       phy_rx_dv,
   input  logic       phy_rx_er,
   input  logic       phy_rx_ce,
   output logic [7:0] mac_rxd,
   output logic       mac_rx_dv,
   output logic       mac_rx_er,
   output logic       mac_rx_valid,
   output logic       rx_odd_nibble
);

   speed_t    active_q, active_d, speed_req_s;
   tx_state_t tx_state_q, tx_state_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       tx_er_q, tx_er_d;
   logic [7:0] phy_txd_q, phy_txd_d;
   logic       phy_tx_en_q, phy_tx_en_d;
   logic       phy_tx_er_q, phy_tx_er_d;
   logic       phy_tx_ce_q;
   logic [7:0] mac_rxd_q, mac_rxd_d;
   logic       mac_rx_dv_q, mac_rx_dv_d;
   logic       mac_rx_er_q, mac_rx_er_d;
   logic       mac_rx_valid_q, mac_rx_valid_d;
   logic       rx_odd_q, rx_odd_d;
   logic       rx_full_q, rx_full_d;
   logic [3:0] rx_nib_q, rx_nib_d;
   logic       rx_nib_er_q, rx_nib_er_d;
   logic       frame_idle_s, div_clear_s, mii_mode_s, ce_s, ready_s;

   // Speed is only switched while both directions sit between frames.
   always_comb begin
      speed_req_s  = norm_speed(speed);
      frame_idle_s = (tx_state_q == IDLE) && !mac_tx_en && !phy_rx_dv && !rx_full_q;
      if (frame_idle_s) begin
         active_d = speed_req_s;
      end else begin
         active_d = active_q;
      end
      div_clear_s = frame_idle_s && (speed_req_s != active_q);
      mii_mode_s  = (active_q != SPEED_1000M);
   end

   gmii_ce_gen #(
      .CLK_DIV_100M (CLK_DIV_100M),
      .CLK_DIV_10M  (CLK_DIV_10M),
      .DIV_WIDTH    (DIV_WIDTH)
   ) u_ce_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .speed (active_q),
      .clear (div_clear_s),
      .ce    (ce_s)
   );

   // TX path: byte pass-through at 1000M, low-then-high nibble FSM otherwise.
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_byte_d   = tx_byte_q;
      tx_er_d     = tx_er_q;
      phy_txd_d   = phy_txd_q;
      phy_tx_en_d = phy_tx_en_q;
      phy_tx_er_d = phy_tx_er_q;
      ready_s     = 1'b0;
      if (!mii_mode_s) begin
         ready_s     = 1'b1;
         phy_txd_d   = mac_txd;
         phy_tx_en_d = mac_tx_en;
         phy_tx_er_d = mac_tx_er;
         tx_state_d  = IDLE;
      end else if (ce_s) begin
         case (tx_state_q)
            HIGH: begin
               phy_txd_d   = {4'h0, tx_byte_q[7:4]};
               phy_tx_en_d = 1'b1;
               phy_tx_er_d = tx_er_q;
               tx_state_d  = LOW;
            end
            // IDLE and LOW both accept a new byte, giving back-to-back frames.
            default: begin
               if (mac_tx_en) begin
                  ready_s     = 1'b1;
                  tx_byte_d   = mac_txd;
                  tx_er_d     = mac_tx_er;
                  phy_txd_d   = {4'h0, mac_txd[3:0]};
                  phy_tx_en_d = 1'b1;
                  phy_tx_er_d = mac_tx_er;
                  tx_state_d  = HIGH;
               end else begin
                  phy_txd_d   = 8'h00;
                  phy_tx_en_d = 1'b0;
                  phy_tx_er_d = 1'b0;
                  tx_state_d  = IDLE;
               end
            end
         endcase
      end else begin
         tx_state_d = tx_state_q;
      end
   end

   // RX path: byte pass-through at 1000M, nibble pairing otherwise.
   always_comb begin
      mac_rxd_d      = mac_rxd_q;
      mac_rx_dv_d    = mac_rx_dv_q;
      mac_rx_er_d    = mac_rx_er_q;
      mac_rx_valid_d = 1'b0;
      rx_odd_d       = 1'b0;
      rx_full_d      = rx_full_q;
      rx_nib_d       = rx_nib_q;
      rx_nib_er_d    = rx_nib_er_q;
      if (!phy_rx_ce) begin
         mac_rx_valid_d = 1'b0;
      end else if (!mii_mode_s) begin
         mac_rxd_d      = phy_rxd;
         mac_rx_dv_d    = phy_rx_dv;
         mac_rx_er_d    = phy_rx_er;
         mac_rx_valid_d = 1'b1;
      end else begin
         case ({phy_rx_dv, rx_full_q})
            2'b10: begin
               rx_nib_d    = phy_rxd[3:0];
               rx_nib_er_d = phy_rx_er;
               rx_full_d   = 1'b1;
            end
            2'b11: begin
               mac_rxd_d      = {phy_rxd[3:0], rx_nib_q};
               mac_rx_dv_d    = 1'b1;
               mac_rx_er_d    = phy_rx_er | rx_nib_er_q;
               mac_rx_valid_d = 1'b1;
               rx_full_d      = 1'b0;
            end
            // Frame ended with a dangling low nibble: flush it as an errored byte.
            2'b01: begin
               mac_rxd_d      = {4'h0, rx_nib_q};
               mac_rx_dv_d    = 1'b1;
               mac_rx_er_d    = 1'b1;
               mac_rx_valid_d = 1'b1;
               rx_odd_d       = 1'b1;
               rx_full_d      = 1'b0;
            end
            default: begin
               mac_rxd_d      = 8'h00;
               mac_rx_dv_d    = 1'b0;
               mac_rx_er_d    = 1'b0;
               mac_rx_valid_d = 1'b1;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q       <= SPEED_1000M;
         tx_state_q     <= IDLE;
         tx_byte_q      <= 8'h00;
         tx_er_q        <= 1'b0;
         phy_txd_q      <= 8'h00;
         phy_tx_en_q    <= 1'b0;
         phy_tx_er_q    <= 1'b0;
         phy_tx_ce_q    <= 1'b0;
         mac_rxd_q      <= 8'h00;
         mac_rx_dv_q    <= 1'b0;
         mac_rx_er_q    <= 1'b0;
         mac_rx_valid_q <= 1'b0;
         rx_odd_q       <= 1'b0;
         rx_full_q      <= 1'b0;
         rx_nib_q       <= 4'h0;
         rx_nib_er_q    <= 1'b0;
      end else begin
         active_q       <= active_d;
         tx_state_q     <= tx_state_d;
         tx_byte_q      <= tx_byte_d;
         tx_er_q        <= tx_er_d;
         phy_txd_q      <= phy_txd_d;
         phy_tx_en_q    <= phy_tx_en_d;
         phy_tx_er_q    <= phy_tx_er_d;
         phy_tx_ce_q    <= ce_s;
         mac_rxd_q      <= mac_rxd_d;
         mac_rx_dv_q    <= mac_rx_dv_d;
         mac_rx_er_q    <= mac_rx_er_d;
         mac_rx_valid_q <= mac_rx_valid_d;
         rx_odd_q       <= rx_odd_d;
         rx_full_q      <= rx_full_d;
         rx_nib_q       <= rx_nib_d;
         rx_nib_er_q    <= rx_nib_er_d;
      end
   end

   // Ready is a same-cycle handshake; forced low while reset is held.
   assign mac_tx_ready  = ready_s & rst_n;
   assign active_speed  = active_q;
   assign phy_txd       = phy_txd_q;
   assign phy_tx_en     = phy_tx_en_q;
   assign phy_tx_er     = phy_tx_er_q;
   assign phy_tx_ce     = phy_tx_ce_q;
   assign mac_rxd       = mac_rxd_q;
   assign mac_rx_dv     = mac_rx_dv_q;
   assign mac_rx_er     = mac_rx_er_q;
   assign mac_rx_valid  = mac_rx_valid_q;
   assign rx_odd_nibble = rx_odd_q;

endmodule

// File: tb/tb_gmii_mii_lane_adapter.sv
// ---------------------------------------------------------------------------
// tb_gmii_mii_lane_adapter
// Directed bench for gmii_mii_lane_adapter. Inputs change 1 time unit after
// the rising edge; registered outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_gmii_mii_lane_adapter;

   logic       clk;
   logic       rst_n;
   logic [1:0] speed;
   logic [1:0] active_speed;
   logic [7:0] mac_txd;
   logic       mac_tx_en;
   logic       mac_tx_er;
   logic       mac_tx_ready;
   logic [7:0] phy_txd;
   logic       phy_tx_en;
   logic       phy_tx_er;
   logic       phy_tx_ce;
   logic [7:0] phy_rxd;
   logic       phy_rx_dv;
   logic       phy_rx_er;
   logic       phy_rx_ce;
   logic [7:0] mac_rxd;
   logic       mac_rx_dv;
   logic       mac_rx_er;
   logic       mac_rx_valid;
   logic       rx_odd_nibble;

   int n_assert;
   int n_fail;

   gmii_mii_lane_adapter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .speed         (speed),
      .active_speed  (active_speed),
      .mac_txd       (mac_txd),
      .mac_tx_en     (mac_tx_en),
      .mac_tx_er     (mac_tx_er),
      .mac_tx_ready  (mac_tx_ready),
      .phy_txd       (phy_txd),
      .phy_tx_en     (phy_tx_en),
      .phy_tx_er     (phy_tx_er),
      .phy_tx_ce     (phy_tx_ce),
      .phy_rxd       (phy_rxd),
      .phy_rx_dv     (phy_rx_dv),
      .phy_rx_er     (phy_rx_er),
      .phy_rx_ce     (phy_rx_ce),
      .mac_rxd       (mac_rxd),
      .mac_rx_dv     (mac_rx_dv),
      .mac_rx_er     (mac_rx_er),
      .mac_rx_valid  (mac_rx_valid),
      .rx_odd_nibble (rx_odd_nibble)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for mac_tx_ready; returns the number of clock edges it took.
   task automatic wait_ready(output int n);
      n = 0;
      #1;
      while (mac_tx_ready !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         #1;
      end
   endtask

   task automatic rx_nib(input logic dv, input logic [3:0] nib);
      phy_rx_dv = dv;
      phy_rxd   = {4'h0, nib};
      phy_rx_ce = 1'b1;
      step();
      phy_rx_ce = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_phy_txd"}, 32'(phy_txd), 32'h0);
      chk({tag, "_phy_tx_en"}, 32'(phy_tx_en), 32'h0);
      chk({tag, "_phy_tx_er"}, 32'(phy_tx_er), 32'h0);
      chk({tag, "_phy_tx_ce"}, 32'(phy_tx_ce), 32'h0);
      chk({tag, "_mac_tx_ready"}, 32'(mac_tx_ready), 32'h0);
      chk({tag, "_mac_rxd"}, 32'(mac_rxd), 32'h0);
      chk({tag, "_mac_rx_dv"}, 32'(mac_rx_dv), 32'h0);
      chk({tag, "_mac_rx_er"}, 32'(mac_rx_er), 32'h0);
      chk({tag, "_mac_rx_valid"}, 32'(mac_rx_valid), 32'h0);
      chk({tag, "_rx_odd"}, 32'(rx_odd_nibble), 32'h0);
      chk({tag, "_active_speed"}, 32'(active_speed), 32'h2);
   endtask

   // Expected 100M TX nibble for bytes A5,3C accepted at cycles 9 and 19.
   function automatic logic [7:0] exp_nib(input int c);
      if (c >= 10 && c <= 14) return 8'h05;
      else if (c >= 15 && c <= 19) return 8'h0A;
      else if (c >= 20 && c <= 24) return 8'h0C;
      else if (c >= 25 && c <= 29) return 8'h03;
      else return 8'h00;
   endfunction

   initial begin
      int n;
      int r_cnt;
      int r_cyc;
      int pend;
      logic [3:0] nibs [4];

      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      speed     = 2'b10;
      mac_txd   = 8'h00;
      mac_tx_en = 1'b0;
      mac_tx_er = 1'b0;
      phy_rxd   = 8'h00;
      phy_rx_dv = 1'b0;
      phy_rx_er = 1'b0;
      phy_rx_ce = 1'b0;

      // Reset state
      step();
      step();
      check_reset("rst");
      rst_n = 1'b1;
      step();

      // 1000M TX pass-through, latency 1, ready always high
      mac_tx_en = 1'b1;
      mac_txd   = 8'h55;
      #1;
      chk("g_ready0", 32'(mac_tx_ready), 32'h1);
      step();
      chk("g_txd0", 32'(phy_txd), 32'h55);
      chk("g_txen0", 32'(phy_tx_en), 32'h1);
      chk("g_txce", 32'(phy_tx_ce), 32'h1);
      mac_txd = 8'hD5;
      #1;
      chk("g_ready1", 32'(mac_tx_ready), 32'h1);
      step();
      chk("g_txd1", 32'(phy_txd), 32'hD5);
      mac_txd = 8'hA1;
      step();
      chk("g_txd2", 32'(phy_txd), 32'hA1);
      mac_tx_en = 1'b0;
      mac_txd   = 8'h00;
      step();
      chk("g_txen_off", 32'(phy_tx_en), 32'h0);

      // 1000M RX pass-through
      phy_rxd   = 8'h5D;
      phy_rx_dv = 1'b1;
      phy_rx_ce = 1'b1;
      step();
      chk("g_rxd", 32'(mac_rxd), 32'h5D);
      chk("g_rxdv", 32'(mac_rx_dv), 32'h1);
      chk("g_rxvalid", 32'(mac_rx_valid), 32'h1);
      phy_rx_ce = 1'b0;
      phy_rx_dv = 1'b0;
      phy_rxd   = 8'h00;
      step();
      chk("g_rxvalid_off", 32'(mac_rx_valid), 32'h0);

      // Speed change requested mid-frame is deferred
      mac_tx_en = 1'b1;
      mac_txd   = 8'h11;
      speed     = 2'b01;
      step();
      chk("defer0", 32'(active_speed), 32'h2);
      step();
      chk("defer1", 32'(active_speed), 32'h2);
      mac_tx_en = 1'b0;
      step();
      chk("apply100", 32'(active_speed), 32'h1);
      // divider restarted at 0: ce at the 5th cycle after the switch
      for (int i = 0; i < 4; i++) begin
         step();
         chk("div_restart_lo", 32'(phy_tx_ce), 32'h0);
      end
      step();
      chk("div_restart_hi", 32'(phy_tx_ce), 32'h1);

      // 100M TX: A5 then 3C back-to-back (now cycle 5 after the switch)
      mac_tx_en = 1'b1;
      mac_txd   = 8'hA5;
      wait_ready(n);
      chk("tx100_wait", 32'(n), 32'd4);
      r_cnt = 1;
      r_cyc = 9;
      pend  = 1;
      for (int c = 10; c <= 31; c++) begin
         step();
         if (pend == 1) begin
            mac_txd = 8'h3C;
         end else if (pend == 2) begin
            mac_tx_en = 1'b0;
            mac_txd   = 8'h00;
         end
         pend = 0;
         chk("tx100_txd", 32'(phy_txd), 32'(exp_nib(c)));
         chk("tx100_en", 32'(phy_tx_en), (c <= 29) ? 32'h1 : 32'h0);
         #1;
         if (mac_tx_ready === 1'b1) begin
            r_cnt++;
            r_cyc = c;
            pend  = 2;
         end
      end
      chk("tx100_ready_cnt", 32'(r_cnt), 32'd2);
      chk("tx100_ready_2nd", 32'(r_cyc), 32'd19);

      // 100M RX: nibbles 1,2,7 then dv=0
      rx_nib(1'b1, 4'h1);
      chk("rx100_n1_valid", 32'(mac_rx_valid), 32'h0);
      repeat (4) step();
      rx_nib(1'b1, 4'h2);
      chk("rx100_b0", 32'(mac_rxd), 32'h21);
      chk("rx100_b0_dv", 32'(mac_rx_dv), 32'h1);
      chk("rx100_b0_er", 32'(mac_rx_er), 32'h0);
      chk("rx100_b0_valid", 32'(mac_rx_valid), 32'h1);
      step();
      chk("rx100_gap_valid", 32'(mac_rx_valid), 32'h0);
      rx_nib(1'b1, 4'h7);
      chk("rx100_n3_valid", 32'(mac_rx_valid), 32'h0);
      repeat (4) step();
      rx_nib(1'b0, 4'h0);
      chk("rx100_odd_b", 32'(mac_rxd), 32'h07);
      chk("rx100_odd_dv", 32'(mac_rx_dv), 32'h1);
      chk("rx100_odd_er", 32'(mac_rx_er), 32'h1);
      chk("rx100_odd_pulse", 32'(rx_odd_nibble), 32'h1);
      step();
      chk("rx100_odd_once", 32'(rx_odd_nibble), 32'h0);

      // 10M RX: nibbles 5,D,1,2 with phy_rx_ce every 50 cycles
      speed = 2'b00;
      step();
      chk("apply10", 32'(active_speed), 32'h0);
      nibs[0] = 4'h5;
      nibs[1] = 4'hD;
      nibs[2] = 4'h1;
      nibs[3] = 4'h2;
      for (int k = 0; k < 4; k++) begin
         rx_nib(1'b1, nibs[k]);
         if (k == 1) begin
            chk("rx10_b0", 32'(mac_rxd), 32'hD5);
            chk("rx10_b0_dv", 32'(mac_rx_dv), 32'h1);
            chk("rx10_b0_er", 32'(mac_rx_er), 32'h0);
            chk("rx10_b0_valid", 32'(mac_rx_valid), 32'h1);
         end else if (k == 3) begin
            chk("rx10_b1", 32'(mac_rxd), 32'h21);
            chk("rx10_b1_dv", 32'(mac_rx_dv), 32'h1);
            chk("rx10_b1_er", 32'(mac_rx_er), 32'h0);
            chk("rx10_b1_valid", 32'(mac_rx_valid), 32'h1);
         end else begin
            chk("rx10_lo_valid", 32'(mac_rx_valid), 32'h0);
         end
         repeat (49) step();
      end
      rx_nib(1'b0, 4'h0);
      chk("rx10_idle_valid", 32'(mac_rx_valid), 32'h1);
      chk("rx10_idle_dv", 32'(mac_rx_dv), 32'h0);
      chk("rx10_idle_er", 32'(mac_rx_er), 32'h0);

      // Reserved speed code maps to 1000M
      speed = 2'b11;
      step();
      chk("speed11", 32'(active_speed), 32'h2);
      speed = 2'b00;
      step();
      chk("back10", 32'(active_speed), 32'h0);

      // 10M TX, then asynchronous reset mid-nibble
      mac_tx_en = 1'b1;
      mac_txd   = 8'h96;
      wait_ready(n);
      chk("tx10_wait", 32'(n), 32'd49);
      step();
      mac_tx_en = 1'b0;
      mac_txd   = 8'h00;
      chk("tx10_lo", 32'(phy_txd), 32'h06);
      chk("tx10_en", 32'(phy_tx_en), 32'h1);
      repeat (10) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("arst");
      speed = 2'b01;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      step();
      chk("post_rst_speed", 32'(active_speed), 32'h1);

      // Clean frame from IDLE after reset
      mac_tx_en = 1'b1;
      mac_txd   = 8'h4B;
      wait_ready(n);
      chk("post_rst_wait", 32'(n), 32'd4);
      step();
      mac_tx_en = 1'b0;
      mac_txd   = 8'h00;
      chk("post_rst_lo", 32'(phy_txd), 32'h0B);
      repeat (5) step();
      chk("post_rst_hi", 32'(phy_txd), 32'h04);
      chk("post_rst_hi_en", 32'(phy_tx_en), 32'h1);
      repeat (5) step();
      chk("post_rst_end_en", 32'(phy_tx_en), 32'h0);
      chk("post_rst_end_txd", 32'(phy_txd), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gmii_mii_lane_adapter.md
Name: gmii_mii_lane_adapter

Overview:
Single-clock GMII/MII lane adapter. Sits between a byte-wide MAC and a PHY interface sampled in the same 125 MHz `clk` domain.
- 1000M: passes bytes through, one per cycle.
- 100M/10M: serialises TX bytes into low-first nibbles on a generated clock enable and reassembles RX nibbles into bytes.
- Speed changes are applied only at frame boundaries.

Parameters:
CLK_DIV_100M, 5, clk cycles per MII nibble at 100M
CLK_DIV_10M, 50, clk cycles per MII nibble at 10M
DIV_WIDTH, 6, divider counter width; must hold CLK_DIV_10M-1

Ports:
clk  in  1  single clock, 125 MHz
rst_n  in  1  reset; asynchronous, active-low
speed  in  2  requested speed: 2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M; 2'b11 is treated as 2'b10
active_speed  out  2  speed currently applied
mac_txd  in  8  TX byte from MAC
mac_tx_en  in  1  TX enable
mac_tx_er  in  1  TX error
mac_tx_ready  out  1  byte accepted this cycle
phy_txd  out  8  TX data to PHY; [7:4]=0 in MII modes
phy_tx_en  out  1  TX enable to PHY
phy_tx_er  out  1  TX error to PHY
phy_tx_ce  out  1  strobe: PHY outputs updated this cycle
phy_rxd  in  8  RX data from PHY; only [3:0] used in MII modes
phy_rx_dv  in  1  RX data valid
phy_rx_er  in  1  RX error
phy_rx_ce  in  1  RX sample qualifier
mac_rxd  out  8  RX byte to MAC
mac_rx_dv  out  1  RX data valid
mac_rx_er  out  1  RX error
mac_rx_valid  out  1  strobe: mac_rx* hold a new byte
rx_odd_nibble  out  1  one-cycle pulse: frame ended on a half byte

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0, except active_speed = 2'b10.
- TX FSM = IDLE, RX nibble buffer empty, divider = 0.

Speed application:
- active_speed loads the normalised speed only on a cycle where the TX FSM is IDLE, mac_tx_en=0 and RX is idle (phy_rx_dv=0, buffer empty).
- A change requested mid-frame is deferred until that point.
- When active_speed loads a new value, the divider clears to 0 on the same edge.

Clock-enable generation (ce):
- 1000M: ce=1 every cycle.
- MII modes: counter runs 0..DIV-1; ce=1 when counter==DIV-1, then wraps to 0.
- phy_tx_ce is ce delayed by one register stage.

TX at 1000M:
- mac_tx_ready=1 continuously.
- phy_txd/en/er <= mac_txd/en/er each cycle; latency 1.

TX at 100M/10M, FSM states IDLE, LOW, HIGH:
- IDLE: on ce with mac_tx_en=1, assert mac_tx_ready for that cycle only. Capture the byte, drive phy_txd={4'h0,byte[3:0]}, phy_tx_en=1, phy_tx_er=tx_er, and go to HIGH.
- IDLE: on ce with mac_tx_en=0, drive phy_tx_en=0, phy_txd=0, phy_tx_er=0.
- HIGH: on ce, drive {4'h0,byte[7:4]} with the same er, then go to LOW.
- LOW: on ce, behave as IDLE. With mac_tx_en=1 this accepts the next byte back-to-back; with mac_tx_en=0 it deasserts phy_tx_en and returns to IDLE.
- The MAC holds data stable until mac_tx_ready. Exactly two ce periods per byte.

RX at 1000M:
- On phy_rx_ce: mac_rxd/dv/er <= phy inputs and mac_rx_valid=1; latency 1.
- Otherwise mac_rx_valid=0.

RX at 100M/10M (only cycles with phy_rx_ce=1 are considered):
- dv=1, buffer empty: store low nibble and its er; no output.
- dv=1, buffer full: output {nibble,stored_low}, dv=1, er = OR of both er bits, mac_rx_valid=1; buffer empties.
- dv=0, buffer full: output {4'h0,stored_low}, dv=1, er=1, mac_rx_valid=1, rx_odd_nibble=1; buffer empties.
- dv=0, buffer empty: output dv=0, er=0, mac_rx_valid=1 on that ce.

Decomposition:
- Package gmii_pkg:
  - speed_t enum: SPEED_10M=2'b00, SPEED_100M=2'b01, SPEED_1000M=2'b10.
  - tx_state_t enum: IDLE, LOW, HIGH.
  - Function normalising 2'b11 to SPEED_1000M.
- Sub-module gmii_ce_gen: divider plus ce output. Inputs: speed, clear. Parameters: CLK_DIV_100M, CLK_DIV_10M, DIV_WIDTH.

Test Plan:
- 1000M, TX bytes 0x55,0xD5,0xA1 with tx_en=1 -> phy_txd shows same bytes one cycle later; mac_tx_ready constantly 1.
- 100M, TX byte 0xA5 then 0x3C, back-to-back -> phy_txd sequence 0x05,0x0A,0x0C,0x03, each held 5 cycles; phy_tx_en high for 20 cycles; mac_tx_ready pulses exactly twice, 10 cycles apart.
- 10M, RX nibbles 0x5,0xD,0x1,0x2 with dv=1, phy_rx_ce every 50 cycles -> mac_rx_valid bytes 0xD5 then 0x21 with dv=1, er=0.
- 100M, RX 3 nibbles 0x1,0x2,0x7 then dv=0 -> bytes 0x21 (er=0), then 0x07 with er=1; rx_odd_nibble pulses once.
- speed changed 2'b10->2'b01 during a TX frame -> active_speed stays 2'b10 until tx_en falls and FSM is IDLE, then 2'b01 with divider restarted at 0; speed=2'b11 -> active_speed=2'b10.
- rst_n asserted mid-nibble at 10M -> all outputs 0 immediately (asynchronous), active_speed=2'b10; after release the next frame starts cleanly from IDLE.
